spi_host_byte_select: RTL
=========================

Name: spi_host_byte_select

Overview:
Downstream of the TX side of the SPI host data CDC, upstream of the core shift register, in the core clock domain.
- Accepts 32-bit TX words with per-byte enables.
- Emits only the enabled bytes, one per handshake, in transmission order.
- Sustains one byte per cycle with no bubble between words.
- Flushes on software reset.

Parameters:
SwapBytes, 1'b0, 0: emit lowest enabled byte lane first (little-endian); 1: emit highest enabled lane first (big-endian).

Ports:
clk_i  input  1  core clock
rst_ni  input  1  asynchronous active-low reset
word_i  input  32  TX word from data CDC
word_be_i  input  4  byte enables of word_i; bit n qualifies word_i[8n+7:8n]
word_valid_i  input  1  word valid
word_ready_o  output  1  word accepted when word_valid_i & word_ready_o
byte_o  output  8  current byte to shift register
byte_valid_o  output  1  byte valid
byte_ready_i  input  1  shift register takes byte when byte_valid_o & byte_ready_i
byte_last_o  output  1  byte_o is the last enabled byte of its word
sw_rst_i  input  1  synchronous flush, already synchronised to clk_i
empty_o  output  1  no bytes held
err_sparse_o  output  1  non-contiguous byte-enable flag (see Optional Feature)

Behaviour:
- Reset (async, active-low) clears all state:
  - data_q = 0, mask_q = 0.
  - Outputs: byte_valid_o = 0, byte_o = 0, byte_last_o = 0, empty_o = 1, word_ready_o = 1, err_sparse_o = 0.
- State:
  - data_q[31:0]: held word.
  - mask_q[3:0]: enabled lanes not yet sent.
- Lane selection:
  - SwapBytes = 0: sel = index of lowest set bit of mask_q.
  - SwapBytes = 1: sel = index of highest set bit of mask_q.
  - byte_o = data_q[8*sel +: 8] when mask_q != 0, else 8'h00.
- Combinational outputs:
  - byte_valid_o = |mask_q.
  - empty_o = ~byte_valid_o.
  - byte_last_o = byte_valid_o & (popcount(mask_q) == 1).
- Byte handshake: clears bit sel of mask_q at the next clk_i edge.
- Word ready:
  - word_ready_o = (mask_q == 0) | (byte_valid_o & byte_ready_i & byte_last_o).
  - This lets the next word load in the same cycle the last byte leaves, giving zero-bubble throughput.
  - word_ready_o is combinationally dependent on byte_ready_i; the downstream must not make byte_ready_i depend on word_ready_o.
- Word load: on word handshake, data_q <= word_i and mask_q <= word_be_i. Load takes priority over the bit-clear of the same cycle.
- Latency: an accepted word's first byte is valid the cycle after acceptance.
- word_be_i == 4'b0000: the word is accepted and discarded, emits no bytes, and word_ready_o stays 1.
- byte_o, byte_valid_o and byte_last_o stay stable while byte_valid_o & ~byte_ready_i.
- sw_rst_i:
  - Sets mask_q <= 0 and data_q <= 0; dominates any simultaneous load or handshake.
  - word_ready_o is forced to 0 while sw_rst_i = 1, so no word is taken during flush.
  - Remaining bytes of a partially sent word are dropped.
- No FSM state beyond mask_q: idle ≡ mask_q == 0, busy otherwise.

Optional Feature:
Macro SPI_HOST_BYTE_SELECT_SPARSE_ERR_EN.
- Defined: err_sparse_o pulses high for one cycle (registered, asserted the cycle after acceptance) when an accepted word has non-contiguous enables: 4'b0101, 4'b1001, 4'b1010, 4'b1011, 4'b1101.
  - Such words are still emitted normally.
  - sw_rst_i clears the pulse register.
- Undefined: err_sparse_o is tied to 1'b0 and no register is built. The port exists in both builds.

Decomposition:
- spi_host_cmd_pkg gains:
  - localparam ByteLanes = 4.
  - typedef logic [ByteLanes-1:0] byte_mask_t.
  - function byte_lane_sel(mask, msb_first) returning the 2-bit lane index.
- One natural sub-module: spi_host_byte_pick.
  - Purely combinational.
  - Inputs: mask, SwapBytes. Outputs: sel, last flag.
  - Reused by the RX packer.

Test Plan:
- SwapBytes=0, word 0x44332211, be 4'hF, byte_ready_i=1 -> bytes 11,22,33,44 on 4 consecutive cycles; byte_last_o=1 only with 44; word_ready_o=1 in the 44 cycle.
- SwapBytes=1, same word -> bytes 44,33,22,11; byte_last_o with 11.
- Two back-to-back words 0x44332211 / 0x88776655, be 4'hF, byte_ready_i held 1 -> 8 bytes in 8 consecutive cycles, no byte_valid_o gap.
- Word 0xDDCCBBAA with be 4'b0101 -> AA then CC; with macro defined err_sparse_o pulses once; without, it stays 0. Word with be 4'b0000 -> no bytes, empty_o stays 1.
- Backpressure: byte_ready_i=0 for 5 cycles on byte 22 -> byte_o holds 22, word_ready_o=0; release -> 33 next.
- sw_rst_i for 1 cycle after 2 of 4 bytes sent -> byte_valid_o=0 and empty_o=1 next cycle; 33 and 44 never appear; word_ready_o=0 during the pulse. Async rst_ni mid-word -> all outputs at reset values immediately.

Source files
------------

// File: rtl/spi_host_cmd_pkg.sv
// Shared SPI host command/data types and byte-lane helpers.
// Used by the TX byte selector and the RX packer.
package spi_host_cmd_pkg;

   localparam int ByteLanes = 4;

   typedef logic [ByteLanes-1:0] byte_mask_t;

   // Lowest set lane, or highest set lane when msb_first.
   function automatic logic [1:0] byte_lane_sel(
      input byte_mask_t mask,
      input logic       msb_first
   );
      logic [1:0] sel;
      sel = '0;
      if (msb_first) begin
         for (int i = 0; i < ByteLanes; i++) begin
            if (mask[i]) sel = i[1:0];
         end
      end else begin
         for (int i = ByteLanes - 1; i >= 0; i--) begin
            if (mask[i]) sel = i[1:0];
         end
      end
      return sel;
   endfunction

   // Enables with a hole between set lanes.
   function automatic logic byte_mask_sparse(
      input byte_mask_t mask
   );
      logic s;
      unique case (mask)
         4'b0101,
         4'b1001,
         4'b1010,
         4'b1011,
         4'b1101: s = 1'b1;
         default: s = 1'b0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/spi_host_byte_pick.sv
// Combinational lane picker: next lane to send and last-lane flag.
// Shared between the TX byte selector and the RX packer.
module spi_host_byte_pick
   import spi_host_cmd_pkg::*;
(
   input  byte_mask_t  mask_i,
   input  logic        swap_i,
   output logic [1:0]  sel_o,
   output logic        last_o
);

   assign sel_o  = byte_lane_sel(mask_i, swap_i);

   // Exactly one bit set: nonzero and clearing the lowest bit leaves zero.
   assign last_o = (mask_i != '0) &&
                   ((mask_i & (mask_i - 1'b1)) == '0);

endmodule

// File: rtl/spi_host_byte_select.sv
// TX word to byte serialiser, one enabled byte per handshake.
// Optional sparse-enable flag: SPI_HOST_BYTE_SELECT_SPARSE_ERR_EN.
module spi_host_byte_select
   import spi_host_cmd_pkg::*;
#(
   parameter logic SwapBytes = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] word_i,
   input  logic [3:0]  word_be_i,
   input  logic        word_valid_i,
   output logic        word_ready_o,
   output logic [7:0]  byte_o,
   output logic        byte_valid_o,
   input  logic        byte_ready_i,
   output logic        byte_last_o,
   input  logic        sw_rst_i,
   output logic        empty_o,
   output logic        err_sparse_o
);

   logic [31:0] data_q, data_d;
   byte_mask_t  mask_q, mask_d;
   logic [1:0]  sel;
   logic        pick_last;
   logic        take;
   logic        load;

   spi_host_byte_pick u_pick (
      .mask_i (mask_q),
      .swap_i (SwapBytes),
      .sel_o  (sel),
      .last_o (pick_last)
   );

   assign byte_valid_o = |mask_q;
   assign empty_o      = ~byte_valid_o;
   assign byte_last_o  = byte_valid_o & pick_last;
   assign byte_o       = byte_valid_o ?
                         data_q[{sel, 3'b000} +: 8] : 8'h00;

   assign take = byte_valid_o & byte_ready_i;

   // Refill in the same cycle the last byte leaves: no bubble.
   assign word_ready_o = ~sw_rst_i &
                         (~byte_valid_o | (take & byte_last_o));

   assign load = word_valid_i & word_ready_o;

   // Next state: clear sent lane, load overrides, flush dominates.
   always_comb begin
      data_d = data_q;
      mask_d = mask_q;
      if (take) begin
         mask_d[sel] = 1'b0;
      end
      if (load) begin
         data_d = word_i;
         mask_d = word_be_i;
      end
      if (sw_rst_i) begin
         data_d = '0;
         mask_d = '0;
      end
   end

   // Held word and pending-lane mask.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
         mask_q <= '0;
      end else begin
         data_q <= data_d;
         mask_q <= mask_d;
      end
   end

`ifdef SPI_HOST_BYTE_SELECT_SPARSE_ERR_EN
   logic err_q, err_d;

   assign err_d = load & byte_mask_sparse(word_be_i);

   // One-cycle pulse after accepting a word with holey enables.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (sw_rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_sparse_o = err_q;
`else
   assign err_sparse_o = 1'b0;
`endif

endmodule
